// File: rtl/hdlc_pkg.sv
// Shared HDLC transmit constants and state encoding.
package hdlc_pkg;
  localparam logic [7:0]  FLAG        = 8'h7E;
  localparam logic [7:0]  ABORT_PAT   = 8'hFE;
  localparam logic [2:0]  STUFF_LIMIT = 3'd5;
  localparam logic [15:0] CRC_POLY    = 16'h8408;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, OPEN_FLAG, DATA, FCS, CLOSE_FLAG, ABORT} tx_state_t;
endpackage

// File: rtl/hdlc_tx_crc16.sv
// Bit-serial reflected CRC-16/X.25; CrcNext includes the bit presented on Din.
module hdlc_tx_crc16
  import hdlc_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Clr,
  input  logic        En,
  input  logic        Din,
  output logic [15:0] CrcNext
);
  logic [15:0] crcReg;
  logic        fb;

  assign fb      = crcReg[0] ^ Din;
  assign CrcNext = (crcReg >> 1) ^ (fb ? CRC_POLY : 16'h0000);

  always_ff @(posedge Clk) begin
    if (Rst || Clr) crcReg <= CRC_INIT;
    else if (En)    crcReg <= CrcNext;
  end
endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flag, zero-stuffed payload, optional FCS (HDLC_TX_FCS_EN), flag.
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Start,
  input  logic       Tx_AbortFrame,
  input  logic [7:0] Tx_DataIn,
  input  logic       Tx_DataValid,
  input  logic       Tx_DataLast,
  output logic       Tx_DataAck,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Underrun,
  output logic       Tx_Done
);
  tx_state_t        state, tgtSt;
  logic [3:0]       bitIdx, tgtIdx;
  logic             stuffNow, lastByte;
  logic [2:0]       onesCnt;
  logic [CNT_W-1:0] byteCnt;
  logic [7:0]       curByte, byteSrc;
  logic             tgtBit, goAbort, fetchPt, ackNow, underrunNow, needStuff;

`ifdef HDLC_TX_FCS_EN
  logic [15:0] crcNext, fcsReg, fcsSrc;

  hdlc_tx_crc16 uCrc (
    .Clk    (Clk),
    .Rst    (Rst),
    .Clr    (state == OPEN_FLAG),
    .En     (state == DATA && !stuffNow),
    .Din    (Tx),
    .CrcNext(crcNext)
  );
`endif

  assign Tx_DataAck = ackNow;

  // While stuffNow is set, state/bitIdx already name the next real bit to send.
  always_comb begin
    tgtSt       = state;
    tgtIdx      = bitIdx + 4'd1;
    goAbort     = 1'b0;
    fetchPt     = 1'b0;
    ackNow      = 1'b0;
    underrunNow = 1'b0;
    if (stuffNow) begin
      tgtIdx  = bitIdx;
      goAbort = Tx_AbortFrame;
    end else begin
      case (state)
        IDLE: begin
          tgtIdx = 4'd0;
          if (Tx_Start) tgtSt = OPEN_FLAG;
        end
        OPEN_FLAG: begin
          goAbort = Tx_AbortFrame;
          fetchPt = (bitIdx == 4'd7);
        end
        DATA: begin
          goAbort = Tx_AbortFrame;
          if (bitIdx == 4'd7) begin
            if (lastByte) begin
`ifdef HDLC_TX_FCS_EN
              tgtSt = FCS;
`else
              tgtSt = CLOSE_FLAG;
`endif
              tgtIdx = 4'd0;
            end else begin
              fetchPt = 1'b1;
            end
          end
        end
`ifdef HDLC_TX_FCS_EN
        FCS: begin
          goAbort = Tx_AbortFrame;
          if (bitIdx == 4'd15) begin
            tgtSt  = CLOSE_FLAG;
            tgtIdx = 4'd0;
          end
        end
`endif
        CLOSE_FLAG, ABORT: if (bitIdx == 4'd7) begin
          tgtSt  = IDLE;
          tgtIdx = 4'd0;
        end
        default: begin
          tgtSt  = IDLE;
          tgtIdx = 4'd0;
        end
      endcase
      if (fetchPt) begin
        underrunNow = !Tx_DataValid;
        if (!Tx_DataValid || byteCnt == CNT_W'(MAX_BYTES)) begin
          goAbort = 1'b1;
        end else if (!goAbort) begin
          ackNow = 1'b1;
          tgtSt  = DATA;
          tgtIdx = 4'd0;
        end
      end
    end
    if (goAbort) begin
      tgtSt  = ABORT;
      tgtIdx = 4'd0;
    end
    byteSrc = ackNow ? Tx_DataIn : curByte;
`ifdef HDLC_TX_FCS_EN
    fcsSrc = (state == DATA) ? ~crcNext : fcsReg;
`endif
    case (tgtSt)
      OPEN_FLAG, CLOSE_FLAG: tgtBit = FLAG[tgtIdx[2:0]];
      DATA:                  tgtBit = byteSrc[tgtIdx[2:0]];
      ABORT:                 tgtBit = ABORT_PAT[tgtIdx[2:0]];
`ifdef HDLC_TX_FCS_EN
      FCS:                   tgtBit = fcsSrc[tgtIdx];
`endif
      default:               tgtBit = 1'b1;
    endcase
    needStuff = !stuffNow && !goAbort && (state == DATA || state == FCS) &&
                (onesCnt == STUFF_LIMIT);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state           <= IDLE;
      bitIdx          <= 4'd0;
      stuffNow        <= 1'b0;
      onesCnt         <= 3'd0;
      byteCnt         <= '0;
      curByte         <= 8'h00;
      lastByte        <= 1'b0;
      Tx              <= 1'b1;
      Tx_ValidFrame   <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Underrun     <= 1'b0;
      Tx_Done         <= 1'b0;
`ifdef HDLC_TX_FCS_EN
      fcsReg          <= 16'h0000;
`endif
    end else begin
      Tx_Done         <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Underrun     <= underrunNow;
      if (ackNow) begin
        curByte  <= Tx_DataIn;
        lastByte <= Tx_DataLast;
        byteCnt  <= byteCnt + 1'b1;
      end
      if (state == IDLE && tgtSt == OPEN_FLAG) begin
        byteCnt       <= '0;
        Tx_ValidFrame <= 1'b1;
      end
      if (goAbort) Tx_ValidFrame <= 1'b0;
      if (state == CLOSE_FLAG && tgtSt == IDLE) begin
        Tx_ValidFrame <= 1'b0;
        Tx_Done       <= 1'b1;
      end
      if (state == ABORT && tgtSt == IDLE) Tx_AbortedTrans <= 1'b1;
`ifdef HDLC_TX_FCS_EN
      if (state == DATA && !stuffNow && tgtSt == FCS) fcsReg <= ~crcNext;
`endif
      state  <= tgtSt;
      bitIdx <= tgtIdx;
      if (needStuff) begin
        Tx       <= 1'b0;
        stuffNow <= 1'b1;
        onesCnt  <= 3'd0;
      end else begin
        Tx       <= tgtBit;
        stuffNow <= 1'b0;
        if (tgtSt == DATA || tgtSt == FCS) onesCnt <= tgtBit ? onesCnt + 3'd1 : 3'd0;
        else                               onesCnt <= 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer; cycle 0 is the cycle Tx_Start is driven.
module tb_hdlc_tx_framer;
  logic       Clk = 1'b0;
  logic       Rst, Tx_Start, Tx_AbortFrame, Tx_DataValid, Tx_DataLast;
  logic [7:0] Tx_DataIn;
  logic       Tx_DataAck, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Underrun, Tx_Done;

  int   nChk = 0, nPass = 0;
  int   ackCnt, vfCnt, doneCyc, abtCyc, undCyc;
  logic txBits [0:2047];
  logic [7:0] bq [$];

  always #5 Clk = ~Clk;

  hdlc_tx_framer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Tx_Start       (Tx_Start),
    .Tx_AbortFrame  (Tx_AbortFrame),
    .Tx_DataIn      (Tx_DataIn),
    .Tx_DataValid   (Tx_DataValid),
    .Tx_DataLast    (Tx_DataLast),
    .Tx_DataAck     (Tx_DataAck),
    .Tx             (Tx),
    .Tx_ValidFrame  (Tx_ValidFrame),
    .Tx_AbortedTrans(Tx_AbortedTrans),
    .Tx_Underrun    (Tx_Underrun),
    .Tx_Done        (Tx_Done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bits in line order, first-sent bit ends up most significant.
  function automatic logic [63:0] seg(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], txBits[from + i]};
    return v;
  endfunction

  task automatic driveData(input int idx, input bit lastEnd, input int dropIdx);
    Tx_DataValid = (idx < bq.size()) && (idx != dropIdx);
    Tx_DataIn    = (idx < bq.size()) ? bq[idx] : 8'h00;
    Tx_DataLast  = lastEnd && (idx == bq.size() - 1);
  endtask

  task automatic idleInputs();
    Tx_Start = 1'b0; Tx_AbortFrame = 1'b0; Tx_DataValid = 1'b0;
    Tx_DataLast = 1'b0; Tx_DataIn = 8'h00;
  endtask

  task automatic doReset();
    idleInputs();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
  endtask

  task automatic runFrame(input int nCyc, input bit lastEnd, input int dropIdx,
                          input int abortCyc, input int startTo, input int restartCyc);
    int idx = 0;
    ackCnt = 0; vfCnt = 0; doneCyc = -1; abtCyc = -1; undCyc = -1;
    for (int i = 0; i < 2048; i++) txBits[i] = 1'b1;
    @(posedge Clk); #1;
    Tx_Start      = 1'b1;
    Tx_AbortFrame = (abortCyc == 0);
    driveData(idx, lastEnd, dropIdx);
    for (int c = 0; c <= nCyc; c++) begin
      @(negedge Clk);
      txBits[c] = Tx;
      if (Tx_ValidFrame) vfCnt++;
      if (Tx_Done && doneCyc < 0) doneCyc = c;
      if (Tx_AbortedTrans && abtCyc < 0) abtCyc = c;
      if (Tx_Underrun && undCyc < 0) undCyc = c;
      if (Tx_DataAck) begin ackCnt++; idx++; end
      @(posedge Clk); #1;
      Tx_Start      = (c + 1 < startTo) || (c + 1 == restartCyc);
      Tx_AbortFrame = (c + 1 == abortCyc);
      driveData(idx, lastEnd, dropIdx);
    end
    idleInputs();
  endtask

  initial begin
    logic [15:0] fcsSeen;
    int bad;
    doReset();

    // Idle after reset, with abort requests that must be ignored.
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      chk("idle", {Tx, Tx_ValidFrame, Tx_DataAck, Tx_AbortedTrans, Tx_Underrun, Tx_Done}, 6'b100000);
      @(posedge Clk); #1;
      Tx_AbortFrame = (c >= 5 && c < 10);
    end
    Tx_AbortFrame = 1'b0;

    // 0x55, Start held into the frame, then restart in the Done cycle.
    bq = {8'h55};
    runFrame(27, 1'b1, -1, -1, 12, 25);
    chk("t55 c0", txBits[0], 1'b1);
    chk("t55 bits", seg(1, 24), 24'h7EAA7E);
    chk("t55 done", doneCyc, 25);
    chk("t55 acks", ackCnt, 1);
    chk("t55 restart", seg(26, 2), 2'b01);
    chk("t55 vf", vfCnt, 26);

    // Reset in the middle of the restarted frame: no abort pattern.
    Rst = 1'b1;
    @(posedge Clk); #1 Rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge Clk);
      if (!Tx || Tx_AbortedTrans || Tx_ValidFrame || Tx_Done) bad++;
    end
    chk("rst mid", bad, 0);

    // 0xFF: stuffed zero after five ones, flags unstuffed.
    bq = {8'hFF};
    runFrame(27, 1'b1, -1, -1, 1, -1);
    chk("tff bits", seg(1, 25), 25'b0111111011111011101111110);
    chk("tff done", doneCyc, 26);

    // Ones run carried across a byte boundary.
    bq = {8'hF0, 8'h0F};
    runFrame(35, 1'b1, -1, -1, 1, -1);
    chk("carry bits", seg(9, 25), 25'b0000111110111000001111110);
    chk("carry done", doneCyc, 34);
    chk("carry acks", ackCnt, 2);

    // Run ending on the last payload bit: stuffed zero before the closing flag.
    bq = {8'hF8};
    runFrame(27, 1'b1, -1, -1, 1, -1);
    chk("tailstuff bits", seg(9, 17), 17'b00011111001111110);
    chk("tailstuff done", doneCyc, 26);

    // Abort requested during data bit 3 of byte 2.
    bq = {8'h00, 8'h0F, 8'h00};
    runFrame(31, 1'b1, -1, 20, 1, -1);
    chk("abort bits", seg(17, 13), 13'b1111011111111);
    chk("abort pulse", abtCyc, 29);
    chk("abort acks", ackCnt, 2);
    chk("abort vf", vfCnt, 20);
    chk("abort done", doneCyc, -1);
    chk("abort und", undCyc, -1);

    // Underrun at the byte-2 fetch point.
    bq = {8'h00, 8'h11};
    runFrame(28, 1'b0, 1, -1, 1, -1);
    chk("und bits", seg(9, 17), 17'b00000000011111111);
    chk("und pulse", undCyc, 17);
    chk("und abt", abtCyc, 25);
    chk("und acks", ackCnt, 1);

    // Start with no data: abort straight after the opening flag.
    bq.delete();
    runFrame(20, 1'b0, -1, -1, 1, -1);
    chk("nodata bits", seg(1, 17), 17'b01111110011111111);
    chk("nodata und", undCyc, 9);
    chk("nodata abt", abtCyc, 17);

    // 129-byte stream: 128 acks, then abort without underrun.
    bq.delete();
    for (int i = 0; i < 129; i++) bq.push_back(8'h00);
    runFrame(1045, 1'b0, -1, -1, 1, -1);
    chk("ovf acks", ackCnt, 128);
    chk("ovf abt", abtCyc, 1041);
    chk("ovf und", undCyc, -1);
    chk("ovf bits", seg(1025, 17), 17'b00000000011111111);

`ifdef HDLC_TX_FCS_EN
    // "123456789": CRC-16/X.25 check value 0x906E, low byte first on the line.
    bq = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    runFrame(107, 1'b1, -1, -1, 1, -1);
    fcsSeen = '0;
    for (int i = 0; i < 16; i++) fcsSeen[i] = txBits[81 + i];
    chk("fcs value", fcsSeen, 16'h906E);
    chk("fcs close", seg(97, 8), 8'b01111110);
    chk("fcs done", doneCyc, 105);
`endif

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
Serial HDLC transmit framer. Accepts frame bytes over a valid/ack handshake and emits one bit per Clk on Tx: opening flag, bit-stuffed payload, optional FCS, closing flag. Handles abort requests and underrun with the 0+7×1 abort pattern, and idles at constant 1. It is the transmit-side counterpart of the Rx deframer and feeds the existing Tx/Tx_ValidFrame/Tx_AbortedTrans assertion checks.

Parameters:
MAX_BYTES, 128, maximum payload bytes per frame; byte MAX_BYTES+1 triggers an abort.
CNT_W, $clog2(MAX_BYTES+1), width of the payload byte counter.

Ports:
Clk  in  1  clock
Rst  in  1  reset, synchronous, active-high
Tx_Start  in  1  frame request; sampled only in IDLE
Tx_AbortFrame  in  1  abort request; honoured in OPEN_FLAG/DATA/FCS
Tx_DataIn  in  8  payload byte, sent LSB first
Tx_DataValid  in  1  Tx_DataIn valid
Tx_DataLast  in  1  qualifies Tx_DataIn as final byte
Tx_DataAck  out  1  1-cycle pulse: byte latched
Tx  out  1  serial line, registered
Tx_ValidFrame  out  1  high from first opening-flag bit through last closing-flag bit
Tx_AbortedTrans  out  1  1-cycle pulse after the last abort-pattern bit
Tx_Underrun  out  1  1-cycle pulse when an abort is caused by missing data
Tx_Done  out  1  1-cycle pulse after the last closing-flag bit

Behaviour:
- Reset (sync, active-high): next edge gives state IDLE, Tx=1, all pulses 0, Tx_ValidFrame=0, counters/CRC cleared. A reset mid-frame produces no abort pattern and no Tx_AbortedTrans.
- Bit rate: one bit per Clk. Tx_Start is sampled in cycle 0. The first flag bit is on Tx in cycle 1.
- States and transitions:
  - IDLE: Tx=1.
  - OPEN_FLAG: 8 bits, 0x7E LSB first (0,1,1,1,1,1,1,0).
  - DATA: payload bits.
  - FCS: 16 bits (macro only).
  - CLOSE_FLAG: 8 bits, 0x7E.
  - ABORT: 8 bits, 0xFE LSB first (0, then seven 1s).
  - Path: IDLE → OPEN_FLAG → DATA → [FCS] → CLOSE_FLAG → IDLE.
- Byte fetch:
  - Tx_DataValid is sampled in the cycle the last bit of the preceding field (flag bit 7 or data bit 7) is on Tx.
  - If valid: latch the byte, pulse Tx_DataAck in that cycle, and start the next bit on the following cycle.
  - If invalid: go to ABORT and pulse Tx_Underrun. Tx_Start with no data therefore aborts right after the opening flag.
- Tx_DataLast on the latched byte: after it, go to FCS (macro) or CLOSE_FLAG.
- Zero insertion:
  - A ones counter runs over DATA and FCS bits. After five consecutive 1s, insert a 0.
  - A stuffed bit consumes no payload bit and does not delay the fetch decision beyond the real last bit.
  - The counter clears on any 0 (real or stuffed) and at OPEN_FLAG entry. It carries across byte boundaries and into FCS.
  - No stuffing in flag or abort fields.
- Abort:
  - Tx_AbortFrame high in OPEN_FLAG/DATA/FCS: the current bit completes, then ABORT starts.
  - Tx_AbortedTrans pulses in the cycle after the last abort bit, then state is IDLE.
  - Tx_ValidFrame drops when ABORT begins.
  - Abort in IDLE/CLOSE_FLAG/ABORT is ignored.
- Overflow: a fetch attempt for byte MAX_BYTES+1 goes to ABORT without acking the byte (Tx_Underrun not pulsed).
- Simultaneous events:
  - Tx_Start outside IDLE is ignored.
  - Abort and underrun in the same cycle: ABORT entered once, Tx_Underrun pulses.
  - Tx_Start in the Tx_Done cycle is accepted (state is IDLE).
- Tx_Done pulses in the first IDLE cycle after a normal close.

Optional Feature:
HDLC_TX_FCS_EN
- Defined:
  - CRC-16/X.25 computed over payload bits before stuffing: reflected poly 0x8408, init 0xFFFF.
  - The complemented register is sent LSB first, 16 bits, stuffed, in state FCS.
  - The CRC is reset at OPEN_FLAG entry.
- Undefined: FCS state and CRC logic absent; DATA goes directly to CLOSE_FLAG.

Decomposition:
- Package hdlc_pkg holds:
  - FLAG = 8'h7E, ABORT_PAT = 8'hFE, STUFF_LIMIT = 5.
  - CRC_POLY = 16'h8408, CRC_INIT = 16'hFFFF.
  - typedef enum tx_state_t {IDLE, OPEN_FLAG, DATA, FCS, CLOSE_FLAG, ABORT}.
- One sub-module: hdlc_tx_crc16, a bit-serial CRC with enable/clear, instantiated only under HDLC_TX_FCS_EN.

Test Plan:
- Reset, no stimulus for 20 cycles → Tx=1 throughout, all pulses 0, Tx_ValidFrame=0.
- Single byte 0x55 with Last, macro off → Tx = 0111_1110, 1010_1010, 0111_1110 (24 bits from cycle 1), no stuffing, Tx_Done pulse in cycle 25.
- Byte 0xFF with Last → data field is 1,1,1,1,1,0,1,1,1 (9 bits); flag is not stuffed; frame is 25 bits.
- Tx_AbortFrame asserted during data bit 3 of byte 2 → bit completes, then 0,1,1,1,1,1,1,1, Tx_AbortedTrans pulse, then Tx=1 idle.
- Tx_DataValid low at the byte-2 fetch point → abort pattern, Tx_Underrun and Tx_AbortedTrans pulses, no Tx_DataAck for byte 2.
- Macro on, payload ASCII "123456789" → FCS bytes 0x6E then 0x90 on the line (stuffed as needed). Separately, a 129-byte stream with MAX_BYTES=128 → 128 acks, then abort.
